// File: rtl/pipeline_hazard_ctrl_if.sv
// Signal bundle between the hazard controller and the IF/ID/EX/WB datapath.
// Perf counter signals exist only when HAZ_PERF_CNT_EN is defined.
interface pipeline_hazard_ctrl_if #(
    parameter int NUM_REGS = 64,
    parameter int REG_AW   = 6,
    parameter int CNT_W    = 16
);
    logic                id_valid;
    logic [REG_AW-1:0]   id_rs;
    logic [REG_AW-1:0]   id_rt;
    logic [REG_AW-1:0]   id_rd;
    logic                id_uses_rs;
    logic                id_uses_rt;
    logic                id_reg_wrt;
    logic                wb_reg_wrt;
    logic [REG_AW-1:0]   wb_rd;
    logic                ex_redirect;

    logic                pc_en;
    logic                ifid_en;
    logic                ifid_flush;
    logic                idex_bubble;
    logic [1:0]          hz_state;
    logic [NUM_REGS-1:0] sb_pending;
`ifdef HAZ_PERF_CNT_EN
    logic [CNT_W-1:0]    stall_cnt;
    logic [CNT_W-1:0]    flush_cnt_total;
    logic [CNT_W-1:0]    issue_cnt;
`endif

    // Datapath side: presents decode/WB/EX status, consumes the pipeline controls.
    modport master (
        output id_valid, id_rs, id_rt, id_rd, id_uses_rs, id_uses_rt, id_reg_wrt,
        output wb_reg_wrt, wb_rd, ex_redirect,
`ifdef HAZ_PERF_CNT_EN
        input  stall_cnt, flush_cnt_total, issue_cnt,
`endif
        input  pc_en, ifid_en, ifid_flush, idex_bubble, hz_state, sb_pending
    );

    // Controller side.
    modport slave (
        input  id_valid, id_rs, id_rt, id_rd, id_uses_rs, id_uses_rt, id_reg_wrt,
        input  wb_reg_wrt, wb_rd, ex_redirect,
`ifdef HAZ_PERF_CNT_EN
        output stall_cnt, flush_cnt_total, issue_cnt,
`endif
        output pc_en, ifid_en, ifid_flush, idex_bubble, hz_state, sb_pending
    );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Scoreboard-based RAW/WAW stall and redirect-squash controller for a 4-stage pipeline.
// Optional saturating performance counters are built when HAZ_PERF_CNT_EN is defined.
module pipeline_hazard_ctrl #(
    parameter int NUM_REGS     = 64,
    parameter int REG_AW       = 6,
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_W        = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    pipeline_hazard_ctrl_if.slave  hz_if
);

    typedef enum logic [1:0] {
        ST_RUN   = 2'b00,
        ST_STALL = 2'b01,
        ST_FLUSH = 2'b10
    } hz_state_t;

    // Out-of-range squash lengths are clamped into the 3-bit down-counter's range.
    localparam int         FLUSH_CLAMP  = (FLUSH_CYCLES < 1) ? 1 :
                                          ((FLUSH_CYCLES > 7) ? 7 : FLUSH_CYCLES);
    localparam logic [2:0] FLUSH_RELOAD = 3'(FLUSH_CLAMP - 1);

    hz_state_t           state_reg, state_next;
    logic [2:0]          flush_cnt_reg, flush_cnt_next;
    logic [NUM_REGS-1:0] sb_reg, sb_next;
    logic [NUM_REGS-1:0] sb_set, sb_clr;

    logic rs_busy, rt_busy, rd_busy;
    logic hz, squash, issue;

    assign rs_busy = hz_if.id_uses_rs & sb_reg[hz_if.id_rs];
    assign rt_busy = hz_if.id_uses_rt & sb_reg[hz_if.id_rt];
    assign rd_busy = hz_if.id_reg_wrt & sb_reg[hz_if.id_rd];

    assign hz     = hz_if.id_valid & (rs_busy | rt_busy | rd_busy);
    assign squash = hz_if.ex_redirect | (state_reg == ST_FLUSH);
    assign issue  = hz_if.id_valid & ~hz & ~squash;

    // Per-entry update: a WB clear and an ID set on the same index resolve to set.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_REGS; gi++) begin : g_sb
            assign sb_clr[gi]  = hz_if.wb_reg_wrt & (hz_if.wb_rd == REG_AW'(gi));
            assign sb_set[gi]  = issue & hz_if.id_reg_wrt & (hz_if.id_rd == REG_AW'(gi));
            assign sb_next[gi] = sb_set[gi] | (sb_reg[gi] & ~sb_clr[gi]);
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= ST_RUN;
            flush_cnt_reg <= '0;
            sb_reg        <= '0;
        end else begin
            state_reg     <= state_next;
            flush_cnt_reg <= flush_cnt_next;
            sb_reg        <= sb_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        flush_cnt_next = flush_cnt_reg;
        case (state_reg)
            ST_RUN: begin
                if (hz_if.ex_redirect) begin
                    state_next     = ST_FLUSH;
                    flush_cnt_next = FLUSH_RELOAD;
                end else if (hz) begin
                    state_next = ST_STALL;
                end
            end
            ST_STALL: begin
                // A redirect drops the stalled instruction; it never issues.
                if (hz_if.ex_redirect) begin
                    state_next     = ST_FLUSH;
                    flush_cnt_next = FLUSH_RELOAD;
                end else if (!hz) begin
                    state_next = ST_RUN;
                end
            end
            ST_FLUSH: begin
                if (hz_if.ex_redirect) begin
                    flush_cnt_next = FLUSH_RELOAD;
                end else if (flush_cnt_reg == 3'd0) begin
                    state_next = ST_RUN;
                end else begin
                    flush_cnt_next = flush_cnt_reg - 3'd1;
                end
            end
            default: begin
                state_next     = ST_RUN;
                flush_cnt_next = '0;
            end
        endcase
    end

    // Squash outranks stall, and both outrank plain run; reset forces a held, flushed front end.
    always_comb begin
        hz_if.pc_en       = 1'b1;
        hz_if.ifid_en     = 1'b1;
        hz_if.ifid_flush  = 1'b0;
        hz_if.idex_bubble = 1'b0;
        if (!rst_n) begin
            hz_if.pc_en       = 1'b0;
            hz_if.ifid_en     = 1'b0;
            hz_if.ifid_flush  = 1'b1;
            hz_if.idex_bubble = 1'b1;
        end else if (squash) begin
            hz_if.ifid_flush  = 1'b1;
            hz_if.idex_bubble = 1'b1;
        end else if (hz) begin
            hz_if.pc_en       = 1'b0;
            hz_if.ifid_en     = 1'b0;
            hz_if.idex_bubble = 1'b1;
        end
    end

    assign hz_if.hz_state   = state_reg;
    assign hz_if.sb_pending = sb_reg;

`ifdef HAZ_PERF_CNT_EN
    localparam int NUM_CNT = 3;

    logic [NUM_CNT-1:0] cnt_inc;

    assign cnt_inc[0] = hz & ~hz_if.ex_redirect;
    assign cnt_inc[1] = hz_if.ifid_flush;
    assign cnt_inc[2] = issue;

    generate
        for (gi = 0; gi < NUM_CNT; gi++) begin : g_cnt
            logic [CNT_W-1:0] cnt_reg;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    cnt_reg <= '0;
                end else if (cnt_inc[gi] && (cnt_reg != {CNT_W{1'b1}})) begin
                    cnt_reg <= cnt_reg + 1'b1;
                end
            end
        end
    endgenerate

    assign hz_if.stall_cnt       = g_cnt[0].cnt_reg;
    assign hz_if.flush_cnt_total = g_cnt[1].cnt_reg;
    assign hz_if.issue_cnt       = g_cnt[2].cnt_reg;
`else
    // CNT_W only sizes the perf counters, which are not built in this configuration.
    if (CNT_W < 1) begin : g_cnt_w_unused
    end
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl: directed scenarios plus randomized traffic
// against a cycle-level behavioural model (scoreboard array, squash countdown, WB delay line).
module tb_pipeline_hazard_ctrl;
    localparam int NUM_REGS     = 64;
    localparam int REG_AW       = 6;
    localparam int FLUSH_CYCLES = 2;
    localparam int CNT_W        = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    pipeline_hazard_ctrl_if #(.NUM_REGS(NUM_REGS), .REG_AW(REG_AW), .CNT_W(CNT_W)) hz_if ();

    pipeline_hazard_ctrl #(
        .NUM_REGS(NUM_REGS), .REG_AW(REG_AW), .FLUSH_CYCLES(FLUSH_CYCLES), .CNT_W(CNT_W)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .hz_if (hz_if)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Reference model: pending-write set, remaining squash cycles, "stuck in ID" flag,
    // and an issue->EX->WB delay line that generates the WB write-back traffic.
    bit [NUM_REGS-1:0] m_sb;
    int                m_flush_left;
    bit                m_stall;
    bit                ex_v, wb_v;
    logic [REG_AW-1:0] ex_rd, wb_rd_q;
`ifdef HAZ_PERF_CNT_EN
    int m_stall_cnt, m_flush_cnt, m_issue_cnt;
`endif

    bit                cur_v, cur_wrt, cur_redir, e_hz, e_issue, e_squash;
    logic [REG_AW-1:0] cur_rd;
    logic [5:0]        exp_ctl, obs_ctl;
    logic [NUM_REGS-1:0] obs_sb;

    task automatic model_reset();
        m_sb = '0; m_flush_left = 0; m_stall = 1'b0;
        ex_v = 1'b0; wb_v = 1'b0; ex_rd = '0; wb_rd_q = '0;
`ifdef HAZ_PERF_CNT_EN
        m_stall_cnt = 0; m_flush_cnt = 0; m_issue_cnt = 0;
`endif
    endtask

    task automatic idle_inputs();
        hz_if.id_valid = 1'b0; hz_if.id_rs = '0; hz_if.id_rt = '0; hz_if.id_rd = '0;
        hz_if.id_uses_rs = 1'b0; hz_if.id_uses_rt = 1'b0; hz_if.id_reg_wrt = 1'b0;
        hz_if.wb_reg_wrt = 1'b0; hz_if.wb_rd = '0; hz_if.ex_redirect = 1'b0;
    endtask

    // Drive one cycle of stimulus at the falling edge, then compute expectations and sample.
    task automatic apply(input bit v, input logic [REG_AW-1:0] rd, rs, rt,
                         input bit urs, urt, wrt, redir);
        @(negedge clk);
        hz_if.id_valid = v; hz_if.id_rd = rd; hz_if.id_rs = rs; hz_if.id_rt = rt;
        hz_if.id_uses_rs = urs; hz_if.id_uses_rt = urt; hz_if.id_reg_wrt = wrt;
        hz_if.wb_reg_wrt = wb_v; hz_if.wb_rd = wb_rd_q; hz_if.ex_redirect = redir;
        cur_v = v; cur_rd = rd; cur_wrt = wrt; cur_redir = redir;
        #1;
        e_hz     = v && ((urs && m_sb[rs]) || (urt && m_sb[rt]) || (wrt && m_sb[rd]));
        e_squash = redir || (m_flush_left > 0);
        e_issue  = v && !e_hz && !e_squash;
        exp_ctl[1:0] = (m_flush_left > 0) ? 2'd2 : (m_stall ? 2'd1 : 2'd0);
        exp_ctl[5:2] = e_squash ? 4'b1111 : (e_hz ? 4'b0001 : 4'b1100);
        obs_ctl = {hz_if.pc_en, hz_if.ifid_en, hz_if.ifid_flush, hz_if.idex_bubble, hz_if.hz_state};
        obs_sb  = hz_if.sb_pending;
        cyc++;
        $display("cyc %0d v=%0b rd=%0d rs=%0d rt=%0d use=%0b%0b%0b wb=%0b/%0d redir=%0b ctl=%b sb=%h",
                 cyc, v, rd, rs, rt, urs, urt, wrt, wb_v, wb_rd_q, redir, obs_ctl, obs_sb);
    endtask

    task automatic advance();
        @(posedge clk);
        if (wb_v) m_sb[wb_rd_q] = 1'b0;
        if (e_issue && cur_wrt) m_sb[cur_rd] = 1'b1;
`ifdef HAZ_PERF_CNT_EN
        if (e_hz && !cur_redir) m_stall_cnt++;
        if (e_squash) m_flush_cnt++;
        if (e_issue) m_issue_cnt++;
`endif
        m_stall      = !e_squash && e_hz;
        m_flush_left = cur_redir ? FLUSH_CYCLES : ((m_flush_left > 0) ? m_flush_left - 1 : 0);
        wb_v    = ex_v;
        wb_rd_q = ex_rd;
        ex_v    = e_issue && cur_wrt;
        ex_rd   = cur_rd;
    endtask

    task automatic drain();
        for (int i = 0; i < 4; i++) begin
            apply(1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
            checks++; if (obs_ctl !== exp_ctl) begin errors++; $display("FAIL drain_ctl cyc=%0d got=%b want=%b", cyc, obs_ctl, exp_ctl); end
            checks++; if (obs_sb !== m_sb) begin errors++; $display("FAIL drain_sb cyc=%0d got=%h want=%h", cyc, obs_sb, m_sb); end
            advance();
        end
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        checks++; if ({hz_if.pc_en, hz_if.ifid_en, hz_if.ifid_flush, hz_if.idex_bubble, hz_if.hz_state} !== 6'b001100) begin
            errors++; $display("FAIL reset_ctl got=%b want=001100", {hz_if.pc_en, hz_if.ifid_en, hz_if.ifid_flush, hz_if.idex_bubble, hz_if.hz_state});
        end
        checks++; if (hz_if.sb_pending !== '0) begin errors++; $display("FAIL reset_sb got=%h want=0", hz_if.sb_pending); end
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_independent();
        for (int i = 0; i < 6; i++) begin
            if (i < 3) apply(1'b1, REG_AW'(i + 1), 6'd10, 6'd11, 1'b1, 1'b1, 1'b1, 1'b0);
            else       apply(1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
            checks++; if (obs_ctl !== exp_ctl) begin errors++; $display("FAIL indep_ctl cyc=%0d got=%b want=%b", cyc, obs_ctl, exp_ctl); end
            checks++; if (obs_sb !== m_sb) begin errors++; $display("FAIL indep_sb cyc=%0d got=%h want=%h", cyc, obs_sb, m_sb); end
            checks++; if (obs_ctl[5:2] !== 4'b1100) begin errors++; $display("FAIL indep_run cyc=%0d got=%b want=1100", cyc, obs_ctl[5:2]); end
            if (i == 5) begin
                checks++; if (obs_sb !== '0) begin errors++; $display("FAIL indep_cleared got=%h want=0", obs_sb); end
            end
            advance();
        end
    endtask

    task automatic test_raw();
        int stalls = 0;
        bit issued = 1'b0;
        drain();
        apply(1'b1, 6'd5, 6'd20, 6'd21, 1'b1, 1'b1, 1'b1, 1'b0);
        checks++; if (obs_ctl !== exp_ctl) begin errors++; $display("FAIL raw_ctl cyc=%0d got=%b want=%b", cyc, obs_ctl, exp_ctl); end
        advance();
        for (int i = 0; i < 8 && !issued; i++) begin
            apply(1'b1, 6'd30, 6'd5, 6'd22, 1'b1, 1'b0, 1'b1, 1'b0);
            checks++; if (obs_ctl !== exp_ctl) begin errors++; $display("FAIL raw_ctl cyc=%0d got=%b want=%b", cyc, obs_ctl, exp_ctl); end
            checks++; if (obs_sb !== m_sb) begin errors++; $display("FAIL raw_sb cyc=%0d got=%h want=%h", cyc, obs_sb, m_sb); end
            if (obs_ctl[5:2] == 4'b0001) stalls++;
            issued = obs_ctl[5];
            advance();
        end
        checks++; if (stalls !== 2 || !issued) begin errors++; $display("FAIL raw_stall_cycles got=%0d issued=%0b want=2 issued=1", stalls, issued); end
    endtask

    task automatic test_waw();
        int stalls = 0;
        bit issued = 1'b0;
        drain();
        apply(1'b1, 6'd7, 6'd0, 6'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        advance();
        for (int i = 0; i < 8 && !issued; i++) begin
            apply(1'b1, 6'd7, 6'd0, 6'd0, 1'b0, 1'b0, 1'b1, 1'b0);
            checks++; if (obs_ctl !== exp_ctl) begin errors++; $display("FAIL waw_ctl cyc=%0d got=%b want=%b", cyc, obs_ctl, exp_ctl); end
            checks++; if (obs_sb !== m_sb) begin errors++; $display("FAIL waw_sb cyc=%0d got=%h want=%h", cyc, obs_sb, m_sb); end
            if (obs_ctl[5:2] == 4'b0001) stalls++;
            issued = obs_ctl[5];
            advance();
        end
        apply(1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
        checks++; if (stalls !== 2 || obs_sb[7] !== 1'b1) begin
            errors++; $display("FAIL waw_result stalls=%0d sb7=%0b want stalls=2 sb7=1", stalls, obs_sb[7]);
        end
        advance();
    endtask

    task automatic test_redirect();
        int flushes = 0;
        drain();
        for (int k = 0; k < 5; k++) begin
            apply(1'b1, REG_AW'(12 + k), 6'd40, 6'd41, 1'b1, 1'b1, 1'b1, k == 0);
            checks++; if (obs_ctl !== exp_ctl) begin errors++; $display("FAIL redir_ctl cyc=%0d got=%b want=%b", cyc, obs_ctl, exp_ctl); end
            checks++; if (obs_sb !== m_sb) begin errors++; $display("FAIL redir_sb cyc=%0d got=%h want=%h", cyc, obs_sb, m_sb); end
            if (obs_ctl[3] && obs_ctl[2]) flushes++;
            advance();
        end
        checks++; if (flushes !== FLUSH_CYCLES + 1) begin errors++; $display("FAIL redir_len got=%0d want=%0d", flushes, FLUSH_CYCLES + 1); end
    endtask

    task automatic test_stall_redirect();
        bit   v_t[7]   = '{1, 1, 1, 1, 1, 1, 0};
        bit   urs_t[7] = '{0, 1, 1, 1, 1, 1, 0};
        bit   rd_t[7]  = '{0, 1, 1, 1, 1, 1, 1};
        bit   red_t[7] = '{0, 0, 1, 1, 0, 0, 0};
        int   flush_states = 0;
        drain();
        for (int c = 0; c < 7; c++) begin
            apply(v_t[c], rd_t[c] ? 6'd13 : 6'd9, 6'd9, 6'd0, urs_t[c], 1'b0, v_t[c], red_t[c]);
            checks++; if (obs_ctl !== exp_ctl) begin errors++; $display("FAIL stredir_ctl cyc=%0d got=%b want=%b", cyc, obs_ctl, exp_ctl); end
            checks++; if (obs_sb !== m_sb) begin errors++; $display("FAIL stredir_sb cyc=%0d got=%h want=%h", cyc, obs_sb, m_sb); end
            if (obs_ctl[1:0] == 2'd2) flush_states++;
            if (c == 6) begin
                checks++; if (obs_ctl[1:0] !== 2'd0 || obs_sb[13] !== 1'b0 || obs_sb[9] !== 1'b0) begin
                    errors++; $display("FAIL stredir_end state=%0d sb13=%0b sb9=%0b want 0 0 0", obs_ctl[1:0], obs_sb[13], obs_sb[9]);
                end
            end
            advance();
        end
        checks++; if (flush_states !== 3) begin errors++; $display("FAIL stredir_flush_len got=%0d want=3", flush_states); end
    endtask

    task automatic test_reset_midflush();
        drain();
        apply(1'b1, 6'd20, 6'd0, 6'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        advance();
        apply(1'b1, 6'd21, 6'd0, 6'd0, 1'b0, 1'b0, 1'b1, 1'b1);
        advance();
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++; if (hz_if.sb_pending !== '0) begin errors++; $display("FAIL midrst_sb got=%h want=0", hz_if.sb_pending); end
        checks++; if ({hz_if.pc_en, hz_if.ifid_en, hz_if.ifid_flush, hz_if.idex_bubble, hz_if.hz_state} !== 6'b001100) begin
            errors++; $display("FAIL midrst_ctl got=%b want=001100", {hz_if.pc_en, hz_if.ifid_en, hz_if.ifid_flush, hz_if.idex_bubble, hz_if.hz_state});
        end
`ifdef HAZ_PERF_CNT_EN
        checks++; if ({hz_if.stall_cnt, hz_if.flush_cnt_total, hz_if.issue_cnt} !== '0) begin
            errors++; $display("FAIL midrst_cnt got=%0d/%0d/%0d want=0/0/0", hz_if.stall_cnt, hz_if.flush_cnt_total, hz_if.issue_cnt);
        end
`endif
        idle_inputs();
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        apply(1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
        checks++; if (obs_ctl !== 6'b110000) begin errors++; $display("FAIL midrst_release got=%b want=110000", obs_ctl); end
        advance();
    endtask

    task automatic test_random();
        bit v = 1'b0, urs = 1'b0, urt = 1'b0, wrt = 1'b0, redir;
        logic [REG_AW-1:0] rd = '0, rs = '0, rt = '0;
        bit held = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (!held) begin
                v   = ($urandom_range(0, 3) != 0);
                rd  = REG_AW'($urandom_range(0, 7));
                rs  = REG_AW'($urandom_range(0, 7));
                rt  = REG_AW'($urandom_range(0, 7));
                urs = 1'($urandom_range(0, 1));
                urt = 1'($urandom_range(0, 1));
                wrt = 1'($urandom_range(0, 1));
            end
            redir = ($urandom_range(0, 9) == 0);
            apply(v, rd, rs, rt, urs, urt, wrt, redir);
            checks++; if (obs_ctl !== exp_ctl) begin errors++; $display("FAIL rand_ctl cyc=%0d got=%b want=%b", cyc, obs_ctl, exp_ctl); end
            checks++; if (obs_sb !== m_sb) begin errors++; $display("FAIL rand_sb cyc=%0d got=%h want=%h", cyc, obs_sb, m_sb); end
            held = e_hz && !e_squash;
            advance();
        end
`ifdef HAZ_PERF_CNT_EN
        apply(1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
        checks++; if (hz_if.stall_cnt !== CNT_W'(m_stall_cnt)) begin errors++; $display("FAIL cnt_stall got=%0d want=%0d", hz_if.stall_cnt, m_stall_cnt); end
        checks++; if (hz_if.flush_cnt_total !== CNT_W'(m_flush_cnt)) begin errors++; $display("FAIL cnt_flush got=%0d want=%0d", hz_if.flush_cnt_total, m_flush_cnt); end
        checks++; if (hz_if.issue_cnt !== CNT_W'(m_issue_cnt)) begin errors++; $display("FAIL cnt_issue got=%0d want=%0d", hz_if.issue_cnt, m_issue_cnt); end
        advance();
`endif
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        test_reset();
        test_independent();
        test_raw();
        test_waw();
        test_redirect();
        test_stall_redirect();
        test_reset_midflush();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
- Sequencing controller for the 4-stage IF/ID/EX/WB datapath.
- Tracks in-flight register writes with a scoreboard and stalls ID on RAW/WAW hazards.
- Squashes wrong-path instructions for a fixed number of cycles after an EX-stage PC redirect.
- Drives PC enable, IF/ID buffer enable/flush and ID/EX bubble insertion.

Parameters:
- NUM_REGS, 64, register file entries (one scoreboard bit each).
- REG_AW, 6, register index width (instr rd [27:22], rs [21:16], rt [15:10]).
- FLUSH_CYCLES, 2, cycles of squash after a redirect; legal range 1..7.
- CNT_W, 16, width of the optional performance counters.

Ports:
- clk  in  1  pipeline clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- id_valid  in  1  ID stage holds a real instruction.
- id_rs  in  REG_AW  ID source register A.
- id_rt  in  REG_AW  ID source register B.
- id_rd  in  REG_AW  ID destination register.
- id_uses_rs  in  1  instruction reads rs.
- id_uses_rt  in  1  instruction reads rt.
- id_reg_wrt  in  1  instruction writes rd (decoded RegWrt).
- wb_reg_wrt  in  1  WB stage commits a register write this cycle.
- wb_rd  in  REG_AW  WB destination register.
- ex_redirect  in  1  EX resolved a taken branch/jump (PC source select != PC+1).
- pc_en  out  1  PC register load enable.
- ifid_en  out  1  IF/ID buffer load enable.
- ifid_flush  out  1  IF/ID buffer loads a NOP.
- idex_bubble  out  1  ID/EX buffer loads a NOP (all control bits 0).
- hz_state  out  2  00 RUN, 01 STALL, 10 FLUSH.
- sb_pending  out  NUM_REGS  scoreboard vector.

Behaviour:
- Reset (rst_n low, async): scoreboard = 0, state = RUN, flush_cnt = 0. While rst_n is low: pc_en=0, ifid_en=0, ifid_flush=1, idex_bubble=1.
- Hazard (combinational): hz = id_valid & ((id_uses_rs & sb[id_rs]) | (id_uses_rt & sb[id_rt]) | (id_reg_wrt & sb[id_rd])).
- Issue: issue = id_valid & ~hz & ~ex_redirect & state != FLUSH.
- Scoreboard update at each clk edge:
  - clear sb[wb_rd] if wb_reg_wrt;
  - then set sb[id_rd] if issue & id_reg_wrt;
  - set wins when both target the same index.
- Cleared register becomes readable the cycle after the WB edge; no same-cycle bypass.
- FSM:
  - RUN: ex_redirect -> FLUSH, flush_cnt = FLUSH_CYCLES-1. Else hz -> STALL. Else stay.
  - STALL: ex_redirect -> FLUSH; the stalled instruction is dropped and never issues. Else ~hz -> RUN. Else stay.
  - FLUSH: flush_cnt counts down. At 0 -> RUN, unless ex_redirect is asserted again, which reloads the count and stays in FLUSH.
- Outputs, priority redirect/FLUSH > hazard > run:
  - ex_redirect or state FLUSH: pc_en=1, ifid_en=1, ifid_flush=1, idex_bubble=1.
  - hz: pc_en=0, ifid_en=0, ifid_flush=0, idex_bubble=1.
  - else: pc_en=1, ifid_en=1, ifid_flush=0, idex_bubble=0.
- Redirect is taken combinationally in the same cycle it is asserted; total squash is FLUSH_CYCLES+1 cycles including the redirect cycle.
- A branch already in EX is never squashed. Its own write (PCToReg) was scoreboarded at issue.
- id_valid=0: no hazard, no issue, outputs as run.
- hz_state is the registered FSM state.

Optional Feature:
- Macro: HAZ_PERF_CNT_EN.
- When defined, adds outputs stall_cnt, flush_cnt_total, issue_cnt (each CNT_W bits).
  - Each counts cycles with hz & ~redirect, cycles with ifid_flush, and issue cycles, respectively.
  - Reset to 0 by rst_n; saturate at all-ones.
- When not defined: ports and logic are absent; remaining behaviour is identical.

Test Plan:
- Reset release, independent stream (rd 1,2,3; rs/rt 10,11) -> pc_en=1 every cycle, idex_bubble=0, sb_pending bits 1,2,3 set at issue and cleared at the matching WB.
- Issue rd=5, then next instr reads rs=5 -> hz_state=STALL, pc_en=0, idex_bubble=1 until the wb_reg_wrt/wb_rd=5 edge; issue on the following cycle (2 stall cycles).
- WAW: issue rd=7, next instr writes rd=7 with no reads -> stall until sb[7] clears, then sb[7]=1 again.
- ex_redirect for one cycle in RUN, FLUSH_CYCLES=2 -> ifid_flush=idex_bubble=1 for 3 cycles, no scoreboard set during them, then RUN.
- ex_redirect while STALLed on r9 -> FLUSH entered, stalled instr never issues, sb[9] still clears at its WB; second redirect during FLUSH reloads the count.
- Assert rst_n low mid-FLUSH with sb nonzero -> immediate sb_pending=0, hz_state=RUN after release. With HAZ_PERF_CNT_EN: counters read 0.
